// File: rtl/gimli_lwc_pkg.sv
// Shared constants and helpers for the gimli_lwc buffers.
// Provides a constant-evaluable clog2 and the pointer/level width derivations so
// every buffer sizes its counters the same way.
package gimli_lwc_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Read/write pointer width for a buffer of the given depth (never zero bits).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gimli_lwc_buffer_mem.sv
// Register-file storage for the gimli_lwc buffers.
// One synchronous write port, one asynchronous read port. Contents are never
// reset; only the surrounding pointer logic decides which entries are valid.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from the stored entry
module gimli_lwc_buffer_mem #(
  parameter int unsigned G_WIDTH = 32,
  parameter int unsigned G_DEPTH = 4,
  parameter int unsigned ADDR_W  = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [G_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [G_WIDTH-1:0] rdata
);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gimli_lwc_buffer_fifo.sv
// Valid/ready FIFO buffer for the gimli_lwc datapath.
// dout is the oldest stored word, read straight from registered storage, so a
// word written in one cycle is visible on dout the next. When full, a push is
// still accepted in the same cycle as a pop (din_ready follows dout_ready).
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all stored words on the next edge
//   din, din_valid, din_ready    : write side handshake
//   dout, dout_valid, dout_ready : read side handshake
//   level, empty, full           : occupancy status
module gimli_lwc_buffer_fifo
  import gimli_lwc_pkg::*;
#(
  parameter int unsigned G_WIDTH = 32,
  parameter int unsigned G_DEPTH = 4,
  localparam int unsigned PTR_W  = ptr_width(G_DEPTH),
  localparam int unsigned LVL_W  = level_width(G_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [G_WIDTH-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [G_WIDTH-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [LVL_W-1:0]   level,
  output logic               empty,
  output logic               full
);

  localparam logic [LVL_W-1:0] LevelFull = LVL_W'(G_DEPTH);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
  localparam logic [LVL_W-1:0] LvlOne    = LVL_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LevelFull);
  assign dout_valid = !empty;
  assign level      = level_q;

  // A full buffer can still take a word when the consumer frees a slot this cycle.
  assign din_ready = !rst && !flush && (!full || dout_ready);

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      // The pop in this cycle completes, but the whole buffer is emptied anyway.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LvlOne;
        2'b01:   level_d = level_q - LvlOne;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  gimli_lwc_buffer_mem #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH),
    .ADDR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

endmodule

// File: tb/tb_gimli_lwc_buffer_fifo.sv
// Directed and scoreboard checks for gimli_lwc_buffer_fifo (32 x 4).
module tb_gimli_lwc_buffer_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [2:0]  level;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  gimli_lwc_buffer_fifo #(
    .G_WIDTH (32),
    .G_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and let outputs settle; inputs are driven after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] words [4];

  initial begin
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444;

    rst = 1'b1; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    settle();
    check("din_ready_in_reset", din_ready, 0);
    tick(); tick();
    rst = 1'b0;
    settle();
    check("reset_level", level, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_din_ready", din_ready, 1);

    // Fill with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      din = words[i]; din_valid = 1'b1;
      settle();
      check("fill_din_ready", din_ready, 1);
      tick();
      check("fill_level", level, 64'(i + 1));
      check("fill_head", dout, 32'h1111_1111);
      check("fill_dout_valid", dout_valid, 1);
    end
    din = 32'h9999_9999;
    settle();
    check("full_flag", full, 1);
    check("full_din_ready", din_ready, 0);
    tick();
    check("full_hold_level", level, 4);
    check("full_hold_dout", dout, 32'h1111_1111);
    check("full_hold_valid", dout_valid, 1);

    // Simultaneous push and pop while full.
    din = 32'h5555_5555; dout_ready = 1'b1;
    settle();
    check("full_pp_din_ready", din_ready, 1);
    check("full_pp_dout", dout, 32'h1111_1111);
    tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    settle();
    check("full_pp_level", level, 4);
    check("full_pp_full", full, 1);
    check("full_pp_next", dout, 32'h2222_2222);

    // Drain and confirm order, including the word written into the freed slot.
    dout_ready = 1'b1;
    check("drain0", dout, 32'h2222_2222); tick();
    check("drain1", dout, 32'h3333_3333); tick();
    check("drain2", dout, 32'h4444_4444); tick();
    check("drain3", dout, 32'h5555_5555); tick();
    check("drain_empty", empty, 1);
    check("drain_dout_valid", dout_valid, 0);
    tick();
    check("no_pop_when_empty", level, 0);

    // Streaming: 10 words, both sides always active.
    for (int k = 0; k <= 10; k++) begin
      din_valid = (k < 10);
      din = 32'(k);
      settle();
      if (k == 0) begin
        check("stream_level0", level, 0);
      end else begin
        check("stream_dout", dout, 64'(k - 1));
        check("stream_valid", dout_valid, 1);
        check("stream_level", level, 1);
      end
      tick();
    end
    din_valid = 1'b0;
    settle();
    check("stream_empty", empty, 1);

    // Single word through an empty buffer with the consumer ready.
    din = 32'hA5A5_A5A5; din_valid = 1'b1;
    settle();
    check("single_dout_valid_n", dout_valid, 0);
    tick();
    din_valid = 1'b0;
    settle();
    check("single_dout_valid_n1", dout_valid, 1);
    check("single_dout", dout, 32'hA5A5_A5A5);
    tick();
    check("single_empty_n2", empty, 1);

    // Flush from level 3 with a push attempt.
    dout_ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'hF000_0000 + 32'(i);
      tick();
    end
    check("pre_flush_level", level, 3);
    flush = 1'b1; din = 32'hDEAD_BEEF;
    settle();
    check("flush_din_ready", din_ready, 0);
    tick();
    flush = 1'b0; din_valid = 1'b0;
    settle();
    check("flush_level", level, 0);
    check("flush_dout_valid", dout_valid, 0);
    check("flush_empty", empty, 1);
    din = 32'hCAFE_BABE; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    settle();
    check("post_flush_head", dout, 32'hCAFE_BABE);
    check("post_flush_level", level, 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("post_flush_drained", empty, 1);

    // Reset from level 2.
    din_valid = 1'b1;
    din = 32'h0BAD_0001; tick();
    din = 32'h0BAD_0002; tick();
    din_valid = 1'b0;
    check("pre_rst_level", level, 2);
    rst = 1'b1;
    settle();
    check("rst_din_ready", din_ready, 0);
    tick();
    rst = 1'b0;
    settle();
    check("rst_level", level, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready_after", din_ready, 1);

    // Random traffic against a queue model.
    q.delete();
    for (int c = 0; c < 300; c++) begin
      din_valid  = 1'($urandom_range(0, 1));
      dout_ready = 1'($urandom_range(0, 1));
      din        = $urandom;
      settle();
      check("rnd_din_ready", din_ready, 64'((q.size() < 4) || dout_ready));
      check("rnd_level", level, 64'(q.size()));
      check("rnd_dout_valid", dout_valid, 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_dout", dout, q[0]);
      end
      if (dout_ready && q.size() != 0) begin
        if (din_valid) q.push_back(din);
        void'(q.pop_front());
      end else if (din_valid && q.size() < 4) begin
        q.push_back(din);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
